// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and defaults for the stopwatch counter.
// Holds the control FSM states and the default configuration.
package stopwatch_bcd_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  localparam int DEF_NUM_DIGITS = 6;
  localparam int DEF_TICK_DIV   = 500000;

  localparam logic [23:0] DEF_DIGIT_MODS = {
    4'd6, 4'd10, 4'd6, 4'd10, 4'd10, 4'd10
  };

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Control pulses in, display and status out.
// The counter core is the slave; the controller is the master.
interface stopwatch_bcd_counter_if #(
  parameter int NUM_DIGITS = 6
) ();

  logic                    start_stop;
  logic                    clear;
  logic                    lap;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    running;
  logic                    lap_active;
  logic                    overflow;
  logic                    tick;

  modport master (
    output start_stop,
    output clear,
    output lap,
    input  digits,
    input  running,
    input  lap_active,
    input  overflow,
    input  tick
  );

  modport slave (
    input  start_stop,
    input  clear,
    input  lap,
    output digits,
    output running,
    output lap_active,
    output overflow,
    output tick
  );

endinterface

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// One modulo-MOD decimal digit of the cascade.
// Carry-out is combinational so a whole ripple lands on one edge.
module bcd_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       cin,
  output logic [3:0] value,
  output logic       cout
);

  if (MOD < 2 || MOD > 10) begin : g_bad_mod
    $error("bcd_digit: MOD must be within 2..10");
  end

  localparam logic [3:0] MAX = 4'(MOD - 1);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (cin) begin
      value_d = (value_q == MAX) ? 4'd0
                                 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign cout  = cin && (value_q == MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timing core: prescaler, run/pause FSM,
// cascaded BCD digits, lap freeze and sticky overflow.
module stopwatch_bcd_counter
  import stopwatch_bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_MODS =
    DEF_DIGIT_MODS,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input logic clk,
  input logic reset,
  stopwatch_bcd_counter_if.slave sw
);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("stopwatch_bcd_counter: TICK_DIV < 1");
  end

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam int DW = 4 * NUM_DIGITS;

  sw_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] lap_q, lap_d;
  logic          lap_act_q, lap_act_d;
  logic          ovf_q, ovf_d;
  logic          tick_q;

  logic          clr_act;
  logic          tick_c;
  logic [DW-1:0] live;
  logic [NUM_DIGITS:0] carry;

  // clear only acts outside RUN, and beats start_stop
  assign clr_act = sw.clear && (state_q != RUN);
  assign tick_c  = (state_q == RUN) && (presc_q == PMAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!sw.clear && sw.start_stop) state_d = RUN;
      end
      RUN: begin
        if (sw.start_stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (sw.clear)           state_d = IDLE;
        else if (sw.start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (clr_act) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      presc_d = tick_c ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    if (clr_act) begin
      lap_act_d = 1'b0;
    end else if (sw.lap) begin
      if (state_q == RUN && !lap_act_q) begin
        lap_d     = live;
        lap_act_d = 1'b1;
      end else begin
        lap_act_d = 1'b0;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q | carry[NUM_DIGITS];
    if (clr_act) ovf_d = 1'b0;
  end

  assign carry[0] = tick_c;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit #(
      .MOD (int'(DIGIT_MODS[4*i +: 4]))
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_act),
      .cin   (carry[i]),
      .value (live[4*i +: 4]),
      .cout  (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      lap_q     <= '0;
      lap_act_q <= 1'b0;
      ovf_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
      ovf_q     <= ovf_d;
      tick_q    <= tick_c;
    end
  end

  assign sw.digits     = lap_act_q ? lap_q : live;
  assign sw.running    = (state_q == RUN);
  assign sw.lap_active = lap_act_q;
  assign sw.overflow   = ovf_q;
  assign sw.tick       = tick_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed vector bench for the stopwatch counter.
// Main DUT uses TICK_DIV=2; a second uses TICK_DIV=1.
module tb_stopwatch_bcd_counter;

  typedef struct {
    logic        rst;
    logic        ss;
    logic        clr;
    logic        lap;
    int          n;
    logic [11:0] dig;
    logic        run;
    logic        lp;
    logic        ovf;
    logic        tk;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  vec_t vq[$];

  stopwatch_bcd_counter_if #(.NUM_DIGITS(3)) sw ();
  stopwatch_bcd_counter_if #(.NUM_DIGITS(3)) sw1 ();

  stopwatch_bcd_counter #(
    .NUM_DIGITS (3),
    .DIGIT_MODS ({4'd6, 4'd10, 4'd10}),
    .TICK_DIV   (2)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .sw    (sw)
  );

  stopwatch_bcd_counter #(
    .NUM_DIGITS (3),
    .DIGIT_MODS ({4'd6, 4'd10, 4'd10}),
    .TICK_DIV   (1)
  ) dut1 (
    .clk   (clk),
    .reset (rst),
    .sw    (sw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s,
                     input logic c, input logic l);
    rst           = r;
    sw.start_stop = s;
    sw.clear      = c;
    sw.lap        = l;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;
  endtask

  task automatic add(input logic r, input logic s,
                     input logic c, input logic l,
                     input int n, input logic [11:0] d,
                     input logic ru, input logic lp,
                     input logic ov, input logic tk);
    vec_t v;
    v.rst = r; v.ss = s; v.clr = c; v.lap = l;
    v.n = n; v.dig = d; v.run = ru; v.lp = lp;
    v.ovf = ov; v.tk = tk;
    vq.push_back(v);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    sw.start_stop = 1'b0;
    sw.clear = 1'b0;
    sw.lap = 1'b0;
    sw1.start_stop = 1'b0;
    sw1.clear = 1'b0;
    sw1.lap = 1'b0;

    //  rst ss clr lap  n     dig    run lp ovf tk
    add(1, 0, 0, 0,    1, 12'h000, 0, 0, 0, 0);
    add(0, 1, 0, 0,    1, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0,   22, 12'h011, 1, 0, 0, 1);
    add(1, 0, 0, 0,    1, 12'h000, 0, 0, 0, 0);
    add(0, 1, 0, 0,    1, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0,   18, 12'h009, 1, 0, 0, 1);
    add(0, 1, 0, 0,    1, 12'h009, 0, 0, 0, 0);
    add(0, 0, 0, 0,   10, 12'h009, 0, 0, 0, 0);
    add(0, 1, 0, 0,    1, 12'h009, 1, 0, 0, 0);
    add(0, 0, 0, 0,    1, 12'h010, 1, 0, 0, 1);
    add(0, 0, 0, 0,   26, 12'h023, 1, 0, 0, 1);
    add(0, 0, 0, 1,    1, 12'h023, 1, 1, 0, 0);
    add(0, 0, 0, 0,   39, 12'h023, 1, 1, 0, 1);
    add(0, 0, 0, 1,    1, 12'h043, 1, 0, 0, 0);
    add(0, 0, 1, 0,    1, 12'h044, 1, 0, 0, 1);
    add(0, 1, 0, 0,    1, 12'h044, 0, 0, 0, 0);
    add(0, 1, 1, 0,    1, 12'h000, 0, 0, 0, 0);
    add(0, 1, 0, 0,    1, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0,    1, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0,    1, 12'h001, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1196, 12'h599, 1, 0, 0, 1);
    add(0, 0, 0, 0,    2, 12'h000, 1, 0, 1, 1);
    add(0, 1, 0, 0,    1, 12'h000, 0, 0, 1, 0);
    add(0, 1, 0, 0,    1, 12'h000, 1, 0, 1, 0);
    add(0, 0, 0, 0,    1, 12'h001, 1, 0, 1, 1);
    add(0, 1, 0, 0,    1, 12'h001, 0, 0, 1, 0);
    add(0, 0, 1, 0,    1, 12'h000, 0, 0, 0, 0);
    add(0, 1, 0, 0,    1, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0,  690, 12'h345, 1, 0, 0, 1);
    add(0, 0, 0, 1,    1, 12'h345, 1, 1, 0, 0);
    add(1, 0, 0, 0,    1, 12'h000, 0, 0, 0, 0);
    add(0, 1, 0, 0,    1, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 1,    1, 12'h000, 1, 1, 0, 0);
    add(0, 0, 0, 0,    4, 12'h000, 1, 1, 0, 0);
    add(0, 1, 0, 0,    1, 12'h000, 0, 1, 0, 1);
    add(0, 0, 0, 1,    1, 12'h003, 0, 0, 0, 0);
    add(0, 1, 0, 0,    1, 12'h003, 1, 0, 0, 0);
    add(0, 0, 0, 0,    1, 12'h003, 1, 0, 0, 0);
    add(0, 0, 0, 1,    1, 12'h003, 1, 1, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst, vq[i].ss, vq[i].clr, vq[i].lap);
      for (int k = 1; k < vq[i].n; k++) cyc(0, 0, 0, 0);
      chk("digits", i, 32'(sw.digits), 32'(vq[i].dig));
      chk("running", i, 32'(sw.running), 32'(vq[i].run));
      chk("lap_active", i, 32'(sw.lap_active),
          32'(vq[i].lp));
      chk("overflow", i, 32'(sw.overflow), 32'(vq[i].ovf));
      chk("tick", i, 32'(sw.tick), 32'(vq[i].tk));
    end

    cyc(1, 0, 0, 0);
    chk("div1_reset_dig", 100, 32'(sw1.digits), 32'h0);
    chk("div1_reset_run", 100, 32'(sw1.running), 32'h0);
    sw1.start_stop = 1'b1;
    @(posedge clk);
    #1;
    sw1.start_stop = 1'b0;
    chk("div1_run", 101, 32'(sw1.running), 32'h1);
    chk("div1_tick0", 101, 32'(sw1.tick), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk("div1_digits", 101 + k, 32'(sw1.digits), 32'(k));
      chk("div1_tick", 101 + k, 32'(sw1.tick), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
